// File: rtl/ahb_sram.sv
// AHB-Lite SRAM slave. Supports byte, halfword and word writes, a configurable
// number of wait states, read-after-write forwarding and two-cycle ERROR responses.
module ahb_sram #(
  parameter int ADDR_WIDTH  = 10,
  parameter int WAIT_STATES = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        HSEL,
  input  logic [31:0] HADDR,
  input  logic [1:0]  HTRANS,
  input  logic        HWRITE,
  input  logic [2:0]  HSIZE,
  input  logic [31:0] HWDATA,
  input  logic        HREADY,
  output logic [31:0] HRDATA,
  output logic        HREADYOUT,
  output logic        HRESP
);

  localparam int         IW    = ADDR_WIDTH - 2;
  localparam int         DEPTH = 1 << IW;
  localparam logic [2:0] WS    = 3'(WAIT_STATES);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_WAIT = 3'd1;
  localparam logic [2:0] S_LAST = 3'd2;
  localparam logic [2:0] S_ERR1 = 3'd3;
  localparam logic [2:0] S_ERR2 = 3'd4;

  logic [2:0]    r_state;
  logic [2:0]    r_cnt;
  logic [IW-1:0] r_idx;
  logic [3:0]    r_be;
  logic          r_write;
  logic [31:0]   r_rdata;
  logic [31:0]   r_mem [DEPTH];

  logic          w_accept;
  logic          w_new;
  logic          w_err;
  logic          w_commit;
  logic          w_rd_load;
  logic [3:0]    w_be;
  logic [IW-1:0] w_idx;
  logic [IW-1:0] w_rd_idx;
  logic [31:0]   w_fwd_word;
  logic [31:0]   w_rd_word;
  logic [2:0]    w_state_nxt;
  logic [2:0]    w_cnt_nxt;
  logic          w_unused;

  assign w_unused  = HTRANS[0];
  assign HRDATA    = r_rdata;
  assign HREADYOUT = !((r_state == S_WAIT) || (r_state == S_ERR1));
  assign HRESP     = (r_state == S_ERR1) || (r_state == S_ERR2);

  // A new address phase is only taken while this slave is not stalling the bus.
  assign w_accept = HSEL & HTRANS[1] & HREADY;
  assign w_new    = w_accept & HREADYOUT;

  assign w_err = (|(HADDR >> ADDR_WIDTH))
               | (HSIZE > 3'd2)
               | ((HSIZE == 3'd1) & HADDR[0])
               | ((HSIZE == 3'd2) & (HADDR[1:0] != 2'b00));

  assign w_idx    = HADDR[ADDR_WIDTH-1:2];
  assign w_commit = (r_state == S_LAST) & r_write;

  always_comb begin
    case (HSIZE)
      3'd0:    w_be = 4'b0001 << HADDR[1:0];
      3'd1:    w_be = HADDR[1] ? 4'b1100 : 4'b0011;
      default: w_be = 4'b1111;
    endcase
  end

  // Word as it will look after the committing write: merged lanes over stored data.
  always_comb begin
    w_fwd_word = r_mem[r_idx];
    for (int n = 0; n < 4; n++) begin
      if (r_be[n]) w_fwd_word[8*n +: 8] = HWDATA[8*n +: 8];
    end
  end

  assign w_rd_idx  = w_new ? w_idx : r_idx;
  assign w_rd_word = (w_commit && (r_idx == w_rd_idx)) ? w_fwd_word : r_mem[w_rd_idx];
  assign w_rd_load = (w_new & ~w_err & ~HWRITE & (WS == 3'd0))
                   | ((r_state == S_WAIT) & (r_cnt == 3'd1) & ~r_write);

  // NOTE: every output of this block is assigned a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = 3'd0;
    case (r_state)
      S_WAIT: begin
        if (r_cnt == 3'd1) w_state_nxt = S_LAST;
        else               w_cnt_nxt   = r_cnt - 3'd1;
      end
      S_ERR1: w_state_nxt = S_ERR2;
      default: begin
        if (!w_new)             w_state_nxt = S_IDLE;
        else if (w_err)         w_state_nxt = S_ERR1;
        else if (WS == 3'd0)    w_state_nxt = S_LAST;
        else begin
          w_state_nxt = S_WAIT;
          w_cnt_nxt   = WS;
        end
      end
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= 3'd0;
      r_idx   <= '0;
      r_be    <= 4'b0000;
      r_write <= 1'b0;
      r_rdata <= 32'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if (w_new) begin
        r_idx   <= w_idx;
        r_be    <= w_be;
        r_write <= HWRITE & ~w_err;
      end
      if (w_rd_load) r_rdata <= w_rd_word;
    end
  end

  // NOTE: the storage array is deliberately not reset; only the commit is gated by rst so an aborted write never lands.
  always_ff @(posedge clk) begin
    if (!rst && w_commit) begin
      for (int n = 0; n < 4; n++) begin
        if (r_be[n]) r_mem[r_idx][8*n +: 8] <= HWDATA[8*n +: 8];
      end
    end
  end

endmodule
